// File: rtl/mdu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mdu_ctrl_pkg
// Purpose  : Funct codes, FSM encodings and decode helpers for the MDU.
// Revision : 1.0 - initial release
// ============================================================================
package mdu_ctrl_pkg;

    localparam logic [5:0] C_FN_MFHI  = 6'h10;
    localparam logic [5:0] C_FN_MTHI  = 6'h11;
    localparam logic [5:0] C_FN_MFLO  = 6'h12;
    localparam logic [5:0] C_FN_MTLO  = 6'h13;
    localparam logic [5:0] C_FN_MULT  = 6'h18;
    localparam logic [5:0] C_FN_MULTU = 6'h19;
    localparam logic [5:0] C_FN_DIV   = 6'h1A;
    localparam logic [5:0] C_FN_DIVU  = 6'h1B;

    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_MUL  = 2'd1;
    localparam logic [1:0] C_ST_DIV  = 2'd2;
    localparam logic [1:0] C_ST_FIX  = 2'd3;

    function automatic logic is_md_op(input logic [5:0] f);
        return f inside {C_FN_MFHI, C_FN_MTHI, C_FN_MFLO, C_FN_MTLO,
                         C_FN_MULT, C_FN_MULTU, C_FN_DIV, C_FN_DIVU};
    endfunction

    function automatic logic is_signed_op(input logic [5:0] f);
        return (f == C_FN_MULT) || (f == C_FN_DIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_core.sv
`default_nettype none
// ============================================================================
// Module   : mdu_core
// Purpose  : One iteration of shift-add multiply or restoring divide.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_core #(
    parameter int WIDTH = 32
) (
    input  logic                   i_mode_div,
    input  logic [2*WIDTH-1:0]     i_acc,
    input  logic [WIDTH-1:0]       i_opnd,
    output logic [2*WIDTH-1:0]     o_acc
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_rem_sh;
    logic [WIDTH:0] w_diff;

    // Multiply: acc = {partial_hi, multiplier}, shifted right each step.
    // Divide:   acc = {remainder, quotient}, shifted left each step; the
    // borrow out of the W+1 bit trial subtract decides the quotient bit.
    always_comb begin
        w_sum    = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_opnd} : '0);
        w_rem_sh = i_acc[2*WIDTH-1:WIDTH-1];
        w_diff   = w_rem_sh - {1'b0, i_opnd};
        if (i_mode_div) begin
            if (w_diff[WIDTH]) begin
                o_acc = {w_rem_sh[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
            end else begin
                o_acc = {w_diff[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
            end
        end else begin
            o_acc = {w_sum, i_acc[WIDTH-1:1]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mdu_ctrl
// Purpose  : Iterative MULT/DIV sequencer owning HI/LO with pipeline stall.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             op_valid,
    input  logic [5:0]       Funct,
    input  logic [WIDTH-1:0] Rdata1,
    input  logic [WIDTH-1:0] Rdata2,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] MfData,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]      C_CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]      C_CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   C_ONE_W    = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] C_ONE_2W   = (2*WIDTH)'(1);

    logic [1:0]         r_state_q,  w_state_d;
    logic [CW-1:0]      r_cnt_q,    w_cnt_d;
    logic [WIDTH-1:0]   r_hi_q,     w_hi_d;
    logic [WIDTH-1:0]   r_lo_q,     w_lo_d;
    logic               r_done_q,   w_done_d;
    logic [2*WIDTH-1:0] r_acc_q,    w_acc_d;
    logic [WIDTH-1:0]   r_opnd_q,   w_opnd_d;
    logic               r_neg_lo_q, w_neg_lo_d;
    logic               r_neg_hi_q, w_neg_hi_d;
    logic               r_is_div_q, w_is_div_d;

    logic               w_md_op;
    logic               w_accept;
    logic               w_sgn;
    logic [WIDTH-1:0]   w_mag1;
    logic [WIDTH-1:0]   w_mag2;
    logic [2*WIDTH-1:0] w_step;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_md_op  = is_md_op(Funct);
    assign w_accept = op_valid & w_md_op & (r_state_q == C_ST_IDLE);
    assign w_sgn    = is_signed_op(Funct);
    assign w_mag1   = (w_sgn & Rdata1[WIDTH-1]) ? (~Rdata1 + C_ONE_W) : Rdata1;
    assign w_mag2   = (w_sgn & Rdata2[WIDTH-1]) ? (~Rdata2 + C_ONE_W) : Rdata2;

    mdu_core #(.WIDTH(WIDTH)) u_core (
        .i_mode_div (r_state_q == C_ST_DIV),
        .i_acc      (r_acc_q),
        .i_opnd     (r_opnd_q),
        .o_acc      (w_step)
    );

    assign w_prod_fix = r_neg_lo_q ? (~r_acc_q + C_ONE_2W) : r_acc_q;
    assign w_quo_fix  = r_neg_lo_q ? (~r_acc_q[WIDTH-1:0] + C_ONE_W) : r_acc_q[WIDTH-1:0];
    assign w_rem_fix  = r_neg_hi_q ? (~r_acc_q[2*WIDTH-1:WIDTH] + C_ONE_W)
                                   : r_acc_q[2*WIDTH-1:WIDTH];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state_q  <= C_ST_IDLE;
            r_cnt_q    <= '0;
            r_hi_q     <= '0;
            r_lo_q     <= '0;
            r_done_q   <= 1'b0;
            r_acc_q    <= '0;
            r_opnd_q   <= '0;
            r_neg_lo_q <= 1'b0;
            r_neg_hi_q <= 1'b0;
            r_is_div_q <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_cnt_q    <= w_cnt_d;
            r_hi_q     <= w_hi_d;
            r_lo_q     <= w_lo_d;
            r_done_q   <= w_done_d;
            r_acc_q    <= w_acc_d;
            r_opnd_q   <= w_opnd_d;
            r_neg_lo_q <= w_neg_lo_d;
            r_neg_hi_q <= w_neg_hi_d;
            r_is_div_q <= w_is_div_d;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            C_ST_IDLE: begin
                if (w_accept) begin
                    if (Funct == C_FN_MULT || Funct == C_FN_MULTU) begin
                        w_state_d = C_ST_MUL;
                    end else if (Funct == C_FN_DIV || Funct == C_FN_DIVU) begin
                        w_state_d = (Rdata2 == '0) ? C_ST_FIX : C_ST_DIV;
                    end
                end
            end
            C_ST_MUL, C_ST_DIV: begin
                if (r_cnt_q == '0) begin
                    w_state_d = C_ST_FIX;
                end
            end
            default: w_state_d = C_ST_IDLE;
        endcase
    end

    always_comb begin
        w_cnt_d    = r_cnt_q;
        w_hi_d     = r_hi_q;
        w_lo_d     = r_lo_q;
        w_acc_d    = r_acc_q;
        w_opnd_d   = r_opnd_q;
        w_neg_lo_d = r_neg_lo_q;
        w_neg_hi_d = r_neg_hi_q;
        w_is_div_d = r_is_div_q;
        w_done_d   = (r_state_q == C_ST_FIX);
        case (r_state_q)
            C_ST_IDLE: begin
                if (w_accept) begin
                    case (Funct)
                        C_FN_MTHI: w_hi_d = Rdata1;
                        C_FN_MTLO: w_lo_d = Rdata1;
                        C_FN_MULT, C_FN_MULTU: begin
                            w_acc_d    = {{WIDTH{1'b0}}, w_mag2};
                            w_opnd_d   = w_mag1;
                            w_neg_lo_d = w_sgn & (Rdata1[WIDTH-1] ^ Rdata2[WIDTH-1]);
                            w_neg_hi_d = 1'b0;
                            w_is_div_d = 1'b0;
                            w_cnt_d    = C_CNT_LAST;
                        end
                        C_FN_DIV, C_FN_DIVU: begin
                            w_is_div_d = 1'b1;
                            // Divide by zero commits the raw dividend and all-ones quotient.
                            if (Rdata2 == '0) begin
                                w_acc_d    = {Rdata1, {WIDTH{1'b1}}};
                                w_neg_lo_d = 1'b0;
                                w_neg_hi_d = 1'b0;
                            end else begin
                                w_acc_d    = {{WIDTH{1'b0}}, w_mag1};
                                w_opnd_d   = w_mag2;
                                w_neg_lo_d = w_sgn & (Rdata1[WIDTH-1] ^ Rdata2[WIDTH-1]);
                                w_neg_hi_d = w_sgn & Rdata1[WIDTH-1];
                                w_cnt_d    = C_CNT_LAST;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            C_ST_MUL, C_ST_DIV: begin
                w_acc_d = w_step;
                w_cnt_d = r_cnt_q - C_CNT_ONE;
            end
            default: begin
                if (r_is_div_q) begin
                    w_lo_d = w_quo_fix;
                    w_hi_d = w_rem_fix;
                end else begin
                    w_hi_d = w_prod_fix[2*WIDTH-1:WIDTH];
                    w_lo_d = w_prod_fix[WIDTH-1:0];
                end
            end
        endcase
    end

    always_comb begin
        busy   = (r_state_q != C_ST_IDLE);
        stall  = op_valid & w_md_op & busy;
        done   = r_done_q;
        hi     = r_hi_q;
        lo     = r_lo_q;
        MfData = (Funct == C_FN_MFHI) ? r_hi_q : r_lo_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_ctrl
// Purpose  : Directed scoreboard bench for the multiply/divide controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_ctrl;

    localparam logic [5:0] C_MFHI  = 6'h10;
    localparam logic [5:0] C_MTHI  = 6'h11;
    localparam logic [5:0] C_MFLO  = 6'h12;
    localparam logic [5:0] C_MULT  = 6'h18;
    localparam logic [5:0] C_MULTU = 6'h19;
    localparam logic [5:0] C_DIV   = 6'h1A;
    localparam logic [5:0] C_DIVU  = 6'h1B;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        op_valid = 1'b0;
    logic [5:0]  Funct = 6'h00;
    logic [31:0] Rdata1 = '0;
    logic [31:0] Rdata2 = '0;
    logic        stall, busy, done;
    logic [31:0] MfData, hi, lo;

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] exp_q[$];

    mdu_ctrl #(.WIDTH(32)) dut (
        .CLK(CLK), .RST(RST), .op_valid(op_valid), .Funct(Funct),
        .Rdata1(Rdata1), .Rdata2(Rdata2), .stall(stall), .busy(busy),
        .done(done), .MfData(MfData), .hi(hi), .lo(lo)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued {hi,lo} result.
    always @(negedge CLK) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("result_hi", {32'd0, hi}, {32'd0, e[63:32]});
                check("result_lo", {32'd0, lo}, {32'd0, e[31:0]});
            end
        end
    end

    task automatic wait_idle(output int n);
        n = 0;
        @(negedge CLK);
        while (busy && n < 200) begin
            n++;
            @(negedge CLK);
        end
    endtask

    task automatic run_op(input string name, input logic [5:0] f,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input int ebusy);
        int n;
        exp_q.push_back({ehi, elo});
        @(negedge CLK);
        op_valid = 1'b1; Funct = f; Rdata1 = a; Rdata2 = b;
        @(posedge CLK);
        #1;
        op_valid = 1'b0; Funct = 6'h00;
        Rdata1 = 32'hA5A5_5A5A; Rdata2 = 32'h0F0F_F0F0;
        wait_idle(n);
        check({name, "_busy_cycles"}, 64'(n), 64'(ebusy));
        check({name, "_done"}, {63'd0, done}, 64'd1);
        @(negedge CLK);
        check({name, "_done_clear"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        int n;
        repeat (2) @(negedge CLK);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        RST = 1'b0;

        run_op("multu_max", C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33);
        run_op("mult_m3x7", C_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33);
        run_op("mult_minsq", C_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 33);
        run_op("divu_100_7", C_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 33);
        run_op("div_m7_2", C_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
        run_op("div_min_m1", C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33);
        run_op("div_by_zero", C_DIV, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF, 1);

        // MTHI: single-cycle write, never busy
        @(negedge CLK);
        op_valid = 1'b1; Funct = C_MTHI; Rdata1 = 32'hDEAD_BEEF;
        @(posedge CLK);
        #1;
        check("mthi_hi", {32'd0, hi}, {32'd0, 32'hDEAD_BEEF});
        check("mthi_busy", {63'd0, busy}, 64'd0);
        op_valid = 1'b0;
        @(negedge CLK);
        Funct = C_MFHI;
        #1;
        check("mfhi_data", {32'd0, MfData}, {32'd0, 32'hDEAD_BEEF});

        // Non-MDU funct is ignored
        op_valid = 1'b1; Funct = 6'h20; Rdata1 = 32'd99;
        #1;
        check("other_stall", {63'd0, stall}, 64'd0);
        @(negedge CLK);
        check("other_busy", {63'd0, busy}, 64'd0);
        op_valid = 1'b0;

        // MFLO held behind a MULTU: stalls the full op, then reads new LO
        exp_q.push_back({32'd0, 32'd42});
        op_valid = 1'b1; Funct = C_MULTU; Rdata1 = 32'd6; Rdata2 = 32'd7;
        @(posedge CLK);
        #1;
        Funct = C_MFLO; Rdata1 = 32'h1111_1111; Rdata2 = 32'h2222_2222;
        n = 0;
        @(negedge CLK);
        while (stall && n < 200) begin
            n++;
            @(negedge CLK);
        end
        check("mflo_stall_cycles", 64'(n), 64'd33);
        check("mflo_done_cycle", {63'd0, done}, 64'd1);
        check("mflo_data", {32'd0, MfData}, 64'd42);
        @(posedge CLK);
        #1;
        op_valid = 1'b0;
        check("mflo_no_busy", {63'd0, busy}, 64'd0);

        // Async reset during a divide: aborts with no done pulse
        @(negedge CLK);
        op_valid = 1'b1; Funct = C_DIV; Rdata1 = 32'd1000; Rdata2 = 32'd3;
        @(posedge CLK);
        #1;
        op_valid = 1'b0;
        repeat (10) @(posedge CLK);
        #2;
        RST = 1'b1;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_hi", {32'd0, hi}, 64'd0);
        check("abort_lo", {32'd0, lo}, 64'd0);
        #1;
        RST = 1'b0;
        repeat (40) @(negedge CLK);
        check("abort_no_done", {63'd0, done}, 64'd0);

        run_op("divu_9_3", C_DIVU, 32'd9, 32'd3, 32'd0, 32'd3, 33);

        repeat (2) @(negedge CLK);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
Multi-cycle multiply/divide unit controller for the EX stage. It owns the architectural HI/LO registers and sequences an iterative 32-step shift-add multiplier and restoring divider. It serves MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO and raises a stall interlock to the pipeline while an operation is in flight. EX forwards R-type mult/div functs here instead of computing them combinationally.

Parameters:
WIDTH, 32, operand/HI/LO width; the iteration count equals WIDTH.

Ports:
CLK  input  1  clock; all state updates on the rising edge
RST  input  1  asynchronous, active-high reset
op_valid  input  1  EX presents an R-type instruction this cycle
Funct  input  6  Ins[5:0]; funct codes from the shared common_param include
Rdata1  input  WIDTH  rs operand (dividend / multiplicand / MT source)
Rdata2  input  WIDTH  rt operand (divisor / multiplier)
stall  output  1  combinational: op_valid & md-op & busy; holds the pipeline
busy  output  1  state != IDLE
done  output  1  one-cycle registered pulse after HI/LO commit of mul/div
MfData  output  WIDTH  combinational: HI when Funct==MFHI, else LO
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (async, any state): state=IDLE, hi=0, lo=0, done=0, counter=0, partial registers=0; any in-flight op is discarded.
- md-op = Funct in {MULT,MULTU,DIV,DIVU,MFHI,MTHI,MFLO,MTLO}. Other functs are ignored: no stall, no state change.
- Accept = op_valid & md-op & state==IDLE.
- MTHI/MTLO accepted: hi/lo <= Rdata1 at that edge. Single cycle; busy never rises.
- MFHI/MFLO accepted: MfData is valid the same cycle. No state change.
- States: IDLE, MUL, DIV, FIX.
- MULT/MULTU accept: latch magnitudes (abs for MULT) and negate flag = sign1^sign2 (MULT only). Set cnt=WIDTH-1, go to MUL.
- DIV/DIVU accept:
  - Rdata2 != 0: latch magnitudes, quotient sign = sign1^sign2, remainder sign = sign1 (DIV only). Set cnt=WIDTH-1, go to DIV.
  - Rdata2 == 0: load q=all-ones, r=Rdata1 and go directly to FIX with no sign fixup.
- MUL: one shift-add step per edge into a 2*WIDTH product. DIV: one restoring step per edge (shift r:q left, trial subtract, set q bit). cnt decrements each edge; the edge with cnt==0 moves to FIX.
- FIX edge: apply two's-complement negation per the latched flags, then write hi/lo (mul: hi=prod[63:32], lo=prod[31:0]; div: lo=quotient, hi=remainder). Set done=1 and go to IDLE.
- done is cleared on the following edge.
- Latency:
  - mul/div: busy high for exactly WIDTH+1 cycles after the accept edge; new hi/lo visible WIDTH+1 edges after accept; done high in the cycle after the commit.
  - Divide by zero: busy high for exactly 1 cycle.
- While busy, any md-op holds stall=1 and is not accepted. The stalled op is accepted on the first IDLE cycle, which is the done cycle. A stalled MFLO therefore reads the new LO.
- Signed corner case: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. The magnitude path is unsigned WIDTH bits, so there is no overflow trap.
- Operands are latched at accept; changes to Rdata1/Rdata2 during busy have no effect.

Decomposition:
- Funct codes (MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B, MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13) and the state encodings live in the shared common_param include.
- One sub-module, mdu_core, holds the combinational single-step datapath (shift-add step and restoring trial-subtract step, selected by a mode bit). mdu_ctrl holds the FSM, counter, sign fixup and HI/LO.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> busy 33 cycles, hi=0xFFFFFFFE, lo=0x00000001, done single pulse.
- MULT -3 x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
- DIVU 100/7 -> lo=14, hi=2. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV 0x12345678/0 -> busy exactly 1 cycle, lo=0xFFFFFFFF, hi=0x12345678.
- MULTU 6x7, then MFLO held op_valid during busy -> stall=1 for 33 cycles, accepted in the done cycle with MfData=42. MTHI 0xDEADBEEF in IDLE -> hi=0xDEADBEEF next cycle, busy stays 0.
- RST pulsed mid-edge during DIV iteration 10 -> busy/hi/lo drop to 0 immediately (async), no done pulse. A subsequent DIVU 9/3 -> lo=3, hi=0.
